// File: rtl/pll_reset_sequencer.sv
// Clock-tree reset sequencer: pulses PLL reset, waits for stable lock, then releases domain resets in order.
// Optional lock-loss/retry statistics are built when RESET_SEQ_STATS_EN is defined.
module pll_reset_sequencer #(
  parameter int NUM_PLLS         = 2,
  parameter int NUM_DOMAINS      = 4,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int STABLE_CYCLES    = 1024,
  parameter int RELEASE_GAP      = 8,
  parameter int LOCK_TIMEOUT     = 65536
) (
  input  logic                   clk_125mhz,
  input  logic                   reset,
  input  logic [NUM_PLLS-1:0]    pll_lock,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             lock_loss_count,
  output logic [7:0]             retry_count
);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [19:0] PRC_LAST = 20'(PLL_RESET_CYCLES - 1);
  localparam logic [19:0] LT_LAST  = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] SC_LAST  = 20'(STABLE_CYCLES - 1);
  localparam logic [19:0] REL_LAST = 20'((NUM_DOMAINS - 1) * RELEASE_GAP);

  logic [NUM_PLLS-1:0]    sync1_q, sync2_q;
  state_t                 state_q, state_d;
  logic [19:0]            cnt_q, cnt_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic                   all_locked;
  logic                   lock_lost;
  logic                   timeout;

  assign all_locked = &sync2_q;

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= S_PLL_RESET;
      cnt_q        <= '0;
      pll_reset_q  <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
    end else begin
      sync1_q      <= pll_lock;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_reset_q  <= pll_reset_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    domain_rst_d = domain_rst_q;
    lock_lost    = 1'b0;
    timeout      = 1'b0;
    unique case (state_q)
      S_PLL_RESET: begin
        domain_rst_d = '1;
        if (cnt_q == PRC_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        domain_rst_d = '1;
        if (all_locked) begin
          state_d = S_STABLE;
        end else if (cnt_q == LT_LAST) begin
          state_d = S_PLL_RESET;
          timeout = 1'b1;
        end
      end
      S_STABLE: begin
        domain_rst_d = '1;
        if (!all_locked) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == SC_LAST) begin
          state_d         = S_RELEASE;
          domain_rst_d[0] = 1'b0;
        end
      end
      S_RELEASE: begin
        // Lock loss wins over any release step due on the same clock.
        if (!all_locked) begin
          lock_lost    = 1'b1;
          domain_rst_d = '1;
          state_d      = S_PLL_RESET;
        end else begin
          for (int i = 1; i < NUM_DOMAINS; i++) begin
            if (cnt_q == 20'(i * RELEASE_GAP - 1)) domain_rst_d[i] = 1'b0;
          end
          if (cnt_q == REL_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!all_locked) begin
          lock_lost    = 1'b1;
          domain_rst_d = '1;
          state_d      = S_PLL_RESET;
        end
      end
      default: begin
        state_d      = S_PLL_RESET;
        domain_rst_d = '1;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (state_q == S_RUN) cnt_d = cnt_q;
    else cnt_d = cnt_q + 20'd1;

    // PLL reset follows the state one clock late, so a lock loss drops domains before re-pulsing the PLLs.
    pll_reset_d = (state_q == S_PLL_RESET);
    ready_d     = (state_d == S_RUN);
  end

  assign pll_reset  = pll_reset_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;

`ifdef RESET_SEQ_STATS_EN
  logic [7:0] lock_loss_q, lock_loss_d;
  logic [7:0] retry_q, retry_d;

  always_comb begin
    lock_loss_d = lock_loss_q;
    retry_d     = retry_q;
    if (lock_lost && (lock_loss_q != 8'hFF)) lock_loss_d = lock_loss_q + 8'd1;
    if (timeout && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      lock_loss_q <= '0;
      retry_q     <= '0;
    end else begin
      lock_loss_q <= lock_loss_d;
      retry_q     <= retry_d;
    end
  end

  assign lock_loss_count = lock_loss_q;
  assign retry_count     = retry_q;
`else
  logic stats_unused;
  assign stats_unused    = lock_lost | timeout;
  assign lock_loss_count = '0;
  assign retry_count     = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: table-driven cold start / run-loss / timeout run, then hand sequences.
// Expected counts follow RESET_SEQ_STATS_EN (zero when the macro is undefined).
module tb_pll_reset_sequencer;
  localparam int NP  = 2;
  localparam int ND  = 4;
  localparam int PRC = 4;
  localparam int SC  = 10;
  localparam int RG  = 3;
  localparam int LT  = 50;
`ifdef RESET_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] lock;
  logic          pll_reset;
  logic [ND-1:0] domain_rst;
  logic          ready;
  logic [7:0]    lock_loss_count;
  logic [7:0]    retry_count;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .NUM_PLLS(NP), .NUM_DOMAINS(ND), .PLL_RESET_CYCLES(PRC),
    .STABLE_CYCLES(SC), .RELEASE_GAP(RG), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_125mhz(clk),
    .reset(rst),
    .pll_lock(lock),
    .pll_reset(pll_reset),
    .domain_rst(domain_rst),
    .ready(ready),
    .lock_loss_count(lock_loss_count),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pr;
    logic [3:0] dr;
    logic       rdy;
    logic [7:0] ll;
    logic [7:0] rc;
  } exp_t;

  typedef struct {
    int         adv;
    logic [1:0] lock;
    logic       pr;
    logic [3:0] dr;
    logic       rdy;
    int         ll;
    int         rc;
  } vec_t;

  exp_t  sb_q[$];
  string tag_q[$];
  vec_t  vecs[21];

  function automatic logic [7:0] cnt_exp(input int v);
    return STATS ? 8'(v) : 8'd0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic pr, input logic [3:0] dr,
                         input logic rdy, input int ll, input int rc);
    exp_t e;
    e.pr  = pr;
    e.dr  = dr;
    e.rdy = rdy;
    e.ll  = cnt_exp(ll);
    e.rc  = cnt_exp(rc);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check();
    exp_t  e;
    string tag;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, need one");
    end else begin
      e   = sb_q.pop_front();
      tag = tag_q.pop_front();
      if ({pll_reset, domain_rst, ready, lock_loss_count, retry_count} !==
          {e.pr, e.dr, e.rdy, e.ll, e.rc}) begin
        errors++;
        $display("FAIL %s: got pr=%b dr=%h rdy=%b ll=%0d rc=%0d, want pr=%b dr=%h rdy=%b ll=%0d rc=%0d",
                 tag, pll_reset, domain_rst, ready, lock_loss_count, retry_count,
                 e.pr, e.dr, e.rdy, e.ll, e.rc);
      end else begin
        $display("ok %s: pr=%b dr=%h rdy=%b ll=%0d rc=%0d", tag, pll_reset, domain_rst, ready,
                 lock_loss_count, retry_count);
      end
    end
  endtask

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("ok %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    lock = '0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int pr_hi;
    int bit2_low;
    int waited;

    // adv = clocks advanced after driving lock, then outputs compared.
    vecs[0]  = '{0,  2'b00, 1'b1, 4'hF, 1'b0, 0, 0};
    vecs[1]  = '{4,  2'b00, 1'b1, 4'hF, 1'b0, 0, 0};
    vecs[2]  = '{1,  2'b00, 1'b0, 4'hF, 1'b0, 0, 0};
    vecs[3]  = '{15, 2'b00, 1'b0, 4'hF, 1'b0, 0, 0};
    vecs[4]  = '{12, 2'b11, 1'b0, 4'hF, 1'b0, 0, 0};
    vecs[5]  = '{1,  2'b11, 1'b0, 4'hE, 1'b0, 0, 0};
    vecs[6]  = '{2,  2'b11, 1'b0, 4'hE, 1'b0, 0, 0};
    vecs[7]  = '{1,  2'b11, 1'b0, 4'hC, 1'b0, 0, 0};
    vecs[8]  = '{3,  2'b11, 1'b0, 4'h8, 1'b0, 0, 0};
    vecs[9]  = '{3,  2'b11, 1'b0, 4'h0, 1'b0, 0, 0};
    vecs[10] = '{1,  2'b11, 1'b0, 4'h0, 1'b1, 0, 0};
    vecs[11] = '{2,  2'b01, 1'b0, 4'h0, 1'b1, 0, 0};
    vecs[12] = '{1,  2'b01, 1'b0, 4'hF, 1'b0, 1, 0};
    vecs[13] = '{1,  2'b01, 1'b1, 4'hF, 1'b0, 1, 0};
    vecs[14] = '{3,  2'b01, 1'b1, 4'hF, 1'b0, 1, 0};
    vecs[15] = '{1,  2'b01, 1'b0, 4'hF, 1'b0, 1, 0};
    vecs[16] = '{48, 2'b01, 1'b0, 4'hF, 1'b0, 1, 0};
    vecs[17] = '{1,  2'b01, 1'b0, 4'hF, 1'b0, 1, 1};
    vecs[18] = '{1,  2'b01, 1'b1, 4'hF, 1'b0, 1, 1};
    vecs[19] = '{54, 2'b01, 1'b1, 4'hF, 1'b0, 1, 2};
    vecs[20] = '{54, 2'b01, 1'b1, 4'hF, 1'b0, 1, 3};

    do_reset();
    for (int k = 0; k < 21; k++) begin
      lock = vecs[k].lock;
      sb_push($sformatf("vec%0d", k), vecs[k].pr, vecs[k].dr, vecs[k].rdy, vecs[k].ll, vecs[k].rc);
      step(vecs[k].adv);
      sb_check();
    end

    // Lock drop during STABLE, restored two clocks later: no PLL reset, release restarts.
    do_reset();
    step(10);
    lock = 2'b11;
    step(5);
    lock  = 2'b00;
    pr_hi = 0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      pr_hi += int'(pll_reset);
    end
    lock = 2'b11;
    for (int i = 0; i < 12; i++) begin
      step(1);
      pr_hi += int'(pll_reset);
    end
    check1("stable_drop_no_pll_reset", pr_hi, 0);
    sb_push("stable_drop_r12", 1'b0, 4'hF, 1'b0, 0, 0);
    sb_check();
    step(1);
    sb_push("stable_drop_r13", 1'b0, 4'hE, 1'b0, 0, 0);
    sb_check();

    // Lock loss seen on the same clock domain_rst[2] would clear.
    do_reset();
    step(10);
    lock = 2'b11;
    step(16);
    sb_push("release_bit1", 1'b0, 4'hC, 1'b0, 0, 0);
    sb_check();
    lock     = 2'b00;
    bit2_low = 0;
    step(2);
    bit2_low += int'(!domain_rst[2]);
    sb_push("release_pre_loss", 1'b0, 4'hC, 1'b0, 0, 0);
    sb_check();
    step(1);
    bit2_low += int'(!domain_rst[2]);
    sb_push("release_loss", 1'b0, 4'hF, 1'b0, 1, 0);
    sb_check();
    lock = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step(1);
      bit2_low += int'(!domain_rst[2]);
    end
    check1("release_bit2_never_low", bit2_low, 0);

    // Recover to RUN, then reset asynchronously mid-cycle.
    waited = 0;
    while (!ready && waited < 80) begin
      step(1);
      waited++;
    end
    check1("recover_ready_reached", int'(ready), 1);
    sb_push("run_before_reset", 1'b0, 4'h0, 1'b1, 1, 0);
    sb_check();
    #2 rst = 1'b1;
    #1;
    sb_push("async_reset", 1'b1, 4'hF, 1'b0, 0, 0);
    sb_check();
    step(1);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
